fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch request and IF/ID handshake.
// Optional one-entry fetch buffer and HOLD state enabled by FETCH_BUFFER_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic        ifW,
    output logic        ifRST
);

`ifdef FETCH_BUFFER_EN
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd2
    } state_t;
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_pc_s;
`ifdef FETCH_BUFFER_EN
    logic [31:0] buf_instr_r;
    logic [31:0] buf_link_r;
    logic [31:0] buf_instr_nxt_s;
    logic [31:0] buf_link_nxt_s;
`endif

    // PC+4 wraps naturally in 32 bits; redirect targets are word aligned.
    assign pc_plus4_s    = pc_r + 32'd4;
    assign redirect_pc_s = redirect_addr & 32'hFFFF_FFFC;
    assign imemaddr      = pc_r;

    // State, PC and buffer registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= FETCH;
            pc_r        <= RESET_PC;
`ifdef FETCH_BUFFER_EN
            buf_instr_r <= 32'h0000_0000;
            buf_link_r  <= 32'h0000_0000;
`endif
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
`ifdef FETCH_BUFFER_EN
            buf_instr_r <= buf_instr_nxt_s;
            buf_link_r  <= buf_link_nxt_s;
`endif
        end
    end

    // Next-state, next-PC and IF/ID handshake outputs.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        imemREN         = 1'b0;
        ifW             = 1'b0;
        ifRST           = 1'b0;
        ifinstr         = imemload;
        ifJALjump_addr  = pc_plus4_s;
`ifdef FETCH_BUFFER_EN
        buf_instr_nxt_s = buf_instr_r;
        buf_link_nxt_s  = buf_link_r;
`endif
        if (RST) begin
            ifRST          = 1'b1;
            ifinstr        = 32'h0000_0000;
            ifJALjump_addr = 32'h0000_0000;
        end else begin
            case (state_r)
                FETCH: begin
                    imemREN = 1'b1;
                    if (redirect) begin
                        // Redirect beats everything, including a pending halt.
                        ifRST       = 1'b1;
                        pc_nxt_s    = redirect_pc_s;
                        state_nxt_s = FETCH;
                    end else if (halt) begin
                        state_nxt_s = HALTED;
                    end else if (ihit && !stall) begin
                        ifW      = 1'b1;
                        pc_nxt_s = pc_plus4_s;
                    end else if (ihit && stall) begin
`ifdef FETCH_BUFFER_EN
                        buf_instr_nxt_s = imemload;
                        buf_link_nxt_s  = pc_plus4_s;
                        pc_nxt_s        = pc_plus4_s;
                        state_nxt_s     = HOLD;
`else
                        // Word dropped; the same PC is refetched once stall clears.
                        pc_nxt_s = pc_r;
`endif
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
`ifdef FETCH_BUFFER_EN
                HOLD: begin
                    ifinstr        = buf_instr_r;
                    ifJALjump_addr = buf_link_r;
                    if (redirect) begin
                        ifRST           = 1'b1;
                        pc_nxt_s        = redirect_pc_s;
                        buf_instr_nxt_s = 32'h0000_0000;
                        buf_link_nxt_s  = 32'h0000_0000;
                        state_nxt_s     = FETCH;
                    end else if (halt) begin
                        state_nxt_s = HALTED;
                    end else if (!stall) begin
                        ifW         = 1'b1;
                        state_nxt_s = FETCH;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
`endif
                HALTED: begin
                    state_nxt_s = HALTED;
                end
                default: begin
                    state_nxt_s = FETCH;
                end
            endcase
        end
    end

endmodule
